unified_mem_arbiter: RTL and testbench

UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

---
 rtl/unified_mem_arbiter_pkg.sv | 24 ++
 rtl/unified_mem_arbiter_pick.sv | 36 +++
 rtl/unified_mem_arbiter.sv | 108 ++++++++++
 tb/tb_unified_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and parameter defaults for the unified instruction/data memory arbiter.
package unified_mem_arbiter_pkg;

  localparam int ADDR_W_DEF     = 6;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  // Counter width able to hold 0..max, never narrower than one bit.
  function automatic int cnt_w(input int max);
    return (max < 2) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/unified_mem_arbiter_pick.sv
// Fetch/data priority select with a saturating fetch-starvation counter.
module mem_arb_pick
  import unified_mem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic d_req,
  input  logic grant,
  output logic grant_d,
  output logic grant_if
);

  localparam int            CW    = cnt_w(STARVE_MAX);
  localparam logic [CW-1:0] MAX_C = CW'(STARVE_MAX);

  logic [CW-1:0] r_starve;

  // Data normally wins; a fetch that has watched STARVE_MAX data grants goes next.
  assign grant_if = if_req & (~d_req | (r_starve == MAX_C));
  assign grant_d  = d_req & ~grant_if;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve <= '0;
    end else if (!if_req) begin
      r_starve <= '0;
    end else if (grant) begin
      if (grant_if)               r_starve <= '0;
      else if (r_starve != MAX_C) r_starve <= r_starve + CW'(1);
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one synchronous memory port between instruction fetch and data access,
// one access per three cycles: IDLE samples, ISSUE drives the port, RESP returns data.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_d
);

  state_e r_state;
  owner_e r_own;
  logic   r_own_we;
  logic   w_grant, w_grant_d, w_grant_if;

  assign w_grant  = (r_state == IDLE) & (if_req | d_req);
  assign stall_if = if_req & ~if_valid;
  assign stall_d  = d_req & ~d_valid;

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .d_req    (d_req),
    .grant    (w_grant),
    .grant_d  (w_grant_d),
    .grant_if (w_grant_if)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_own     <= OWN_IF;
      r_own_we  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_valid  <= 1'b0;
      d_valid   <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_state <= ISSUE;
            mem_en  <= 1'b1;
            if (w_grant_d) begin
              r_own     <= OWN_D;
              r_own_we  <= d_we;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else begin
              // Fetches leave mem_wdata untouched.
              r_own    <= OWN_IF;
              r_own_we <= 1'b0;
              mem_we   <= 1'b0;
              mem_addr <= if_addr;
            end
          end
        end
        ISSUE: begin
          r_state <= RESP;
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
        end
        RESP: begin
          r_state <= IDLE;
          if (r_own == OWN_D) begin
            d_valid <= 1'b1;
            if (!r_own_we) d_rdata <= mem_rdata;
          end else begin
            if_valid <= 1'b1;
            if_rdata <= mem_rdata;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed vector table, corner sequences, and
// randomized requesters checked against a transaction-level model.
module tb_unified_mem_arbiter;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int SM = 2;
  localparam int NW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          d_req, d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          d_valid;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          stall_if, stall_d;

  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;
  logic [DW-1:0] mem     [NW];
  logic [DW-1:0] ref_mem [NW];

  int vecs, errs;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_d(stall_d)
  );

  // Synchronous single-port memory; preload port used only while in reset.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic preload();
    logic [DW-1:0] v;
    for (int i = 0; i < NW; i++) begin
      v = $urandom;
      if (i == 3) v = 32'h3333_3333;
      if (i == 5) v = 32'h00A0_0093;
      if (i == 9) v = 32'h9999_9999;
      pl_en = 1'b1; pl_addr = AW'(i); pl_data = v;
      ref_mem[i] = v;
      tick();
    end
    pl_en = 1'b0;
  endtask

  typedef struct {
    bit            fetch;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t tbl [7];

  task automatic run_one(input vec_t v, input string nm);
    int n, en_cnt, we_cnt;
    bit seen;
    n = 0; en_cnt = 0; we_cnt = 0; seen = 0;
    if (v.fetch) begin
      if_req = 1'b1; if_addr = v.addr;
    end else begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end
    while (!seen && n < 8) begin
      tick(); n++;
      en_cnt += int'(mem_en);
      we_cnt += int'(mem_we);
      seen = v.fetch ? if_valid : d_valid;
    end
    chk({nm, " latency"}, n, 3);
    chk({nm, " mem_en cycles"}, en_cnt, 1);
    chk({nm, " mem_we cycles"}, we_cnt, v.we ? 1 : 0);
    if (v.fetch) begin
      chk({nm, " if_rdata"}, if_rdata, v.exp_rdata);
      chk({nm, " stall_if"}, stall_if, 0);
    end else begin
      chk({nm, " d_rdata"}, d_rdata, v.exp_rdata);
      chk({nm, " stall_d"}, stall_d, 0);
    end
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    tick();
  endtask

  // Transaction-level reference: one access at a time, next sample 3 edges after a grant.
  int            m_e, m_free, m_done, m_starve;
  bit            m_pend, m_own_d, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, e_ird, e_drd;
  bit            e_ifv, e_dv, e_en, e_we;

  task automatic model_step();
    bit win_if, arb;
    e_ifv = 0; e_dv = 0; e_en = 0; e_we = 0;
    if (m_pend && m_e == m_done) begin
      m_pend = 0;
      if (m_own_d) begin
        e_dv = 1;
        if (m_we) ref_mem[m_addr] = m_wdata;
        else      e_drd = ref_mem[m_addr];
      end else begin
        e_ifv = 1;
        e_ird = ref_mem[m_addr];
      end
    end
    arb    = (m_e >= m_free) && (if_req || d_req);
    win_if = if_req && (!d_req || m_starve == SM);
    if (!if_req)        m_starve = 0;
    else if (arb)       m_starve = win_if ? 0 : ((m_starve < SM) ? m_starve + 1 : SM);
    if (arb) begin
      m_pend  = 1;
      m_done  = m_e + 2;
      m_free  = m_e + 3;
      m_own_d = !win_if;
      m_we    = !win_if && d_we;
      m_addr  = win_if ? if_addr : d_addr;
      m_wdata = d_wdata;
      e_en    = 1;
      e_we    = m_we;
    end
    m_e++;
  endtask

  initial begin
    vecs = 0; errs = 0;
    rst = 1'b0;
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    pl_en = 0; pl_addr = '0; pl_data = '0;

    tbl[0] = '{1'b1, 1'b0, 6'd5, 32'h0,         32'h00A0_0093};
    tbl[1] = '{1'b0, 1'b0, 6'd3, 32'h0,         32'h3333_3333};
    tbl[2] = '{1'b0, 1'b1, 6'd7, 32'hDEAD_BEEF, 32'h3333_3333};
    tbl[3] = '{1'b0, 1'b0, 6'd7, 32'h0,         32'hDEAD_BEEF};
    tbl[4] = '{1'b1, 1'b0, 6'd7, 32'h0,         32'hDEAD_BEEF};
    tbl[5] = '{1'b0, 1'b1, 6'd0, 32'h1234_5678, 32'hDEAD_BEEF};
    tbl[6] = '{1'b0, 1'b0, 6'd0, 32'h0,         32'h1234_5678};

    preload();
    chk("rst mem_en",    mem_en,    0);
    chk("rst mem_we",    mem_we,    0);
    chk("rst mem_addr",  mem_addr,  0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst if_rdata",  if_rdata,  0);
    chk("rst d_rdata",   d_rdata,   0);
    chk("rst if_valid",  if_valid,  0);
    chk("rst d_valid",   d_valid,   0);
    rst = 1'b1;

    foreach (tbl[i]) run_one(tbl[i], $sformatf("vec%0d", i));

    // Simultaneous fetch and data read: data first, fetch three cycles later.
    begin
      int n, de, ie;
      n = 0; de = 0; ie = 0;
      if_req = 1; if_addr = 6'd5; d_req = 1; d_we = 0; d_addr = 6'd3;
      while ((de == 0 || ie == 0) && n < 15) begin
        tick(); n++;
        if (d_valid) begin
          de = n; chk("coll d_rdata", d_rdata, 32'h3333_3333); d_req = 0;
        end
        if (if_valid) begin
          ie = n; chk("coll if_rdata", if_rdata, 32'h00A0_0093); if_req = 0;
        end
      end
      chk("coll d edge", de, 3);
      chk("coll if edge", ie, 6);
      tick();
    end

    // Continuous data traffic with a waiting fetch: D, D, IF, D, D, IF.
    begin
      bit exp_if [6];
      int k, n;
      exp_if = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      k = 0; n = 0;
      if_req = 1; if_addr = 6'd1; d_req = 1; d_we = 0; d_addr = 6'd10;
      while (k < 6 && n < 40) begin
        tick(); n++;
        if (d_valid || if_valid) begin
          chk($sformatf("starve grant%0d is_if", k), if_valid, exp_if[k]);
          k++;
          if (d_valid)  d_addr  = d_addr + 1'b1;
          if (if_valid) if_addr = if_addr + 1'b1;
        end
      end
      chk("starve completions", k, 6);
      if_req = 0; d_req = 0;
      tick();
    end

    // Reset landing in ISSUE of a write aborts it.
    begin
      int dv;
      dv = 0;
      d_req = 1; d_we = 1; d_addr = 6'd9; d_wdata = 32'hCAFE_F00D;
      tick();
      chk("rstw issuing mem_we", mem_we, 1);
      #1 rst = 1'b0; d_req = 0; d_we = 0;
      #1;
      chk("rstw mem_en",    mem_en,    0);
      chk("rstw mem_we",    mem_we,    0);
      chk("rstw mem_addr",  mem_addr,  0);
      chk("rstw mem_wdata", mem_wdata, 0);
      chk("rstw d_rdata",   d_rdata,   0);
      chk("rstw if_rdata",  if_rdata,  0);
      repeat (3) begin tick(); dv += int'(d_valid); end
      chk("rstw d_valid pulses", dv, 0);
      rst = 1'b1;
      chk("rstw mem9", mem[9], 32'h9999_9999);
      run_one('{1'b0, 1'b0, 6'd9, 32'h0, 32'h9999_9999}, "rstw readback");
    end

    // One-cycle data request present only during RESP is never sampled.
    begin
      int en, dv;
      en = 0; dv = 0;
      if_req = 1; if_addr = 6'd5;
      tick(); tick();
      d_req = 1; d_we = 1; d_addr = 6'd12; d_wdata = 32'h0BAD_0BAD;
      tick();
      chk("glitch if_valid", if_valid, 1);
      d_req = 0; d_we = 0; if_req = 0;
      repeat (5) begin tick(); en += int'(mem_en); dv += int'(d_valid); end
      chk("glitch mem_en cycles", en, 0);
      chk("glitch d_valid pulses", dv, 0);
      chk("glitch mem12", mem[12], ref_mem[12]);
    end

    // Randomized requesters against the reference model.
    rst = 1'b0;
    preload();
    rst = 1'b1;
    m_e = 0; m_free = 0; m_done = 0; m_starve = 0; m_pend = 0;
    m_own_d = 0; m_we = 0; m_addr = '0; m_wdata = '0; e_ird = '0; e_drd = '0;
    for (int c = 0; c < 600; c++) begin
      model_step();
      tick();
      chk("rnd if_valid", if_valid, e_ifv);
      chk("rnd d_valid",  d_valid,  e_dv);
      chk("rnd if_rdata", if_rdata, e_ird);
      chk("rnd d_rdata",  d_rdata,  e_drd);
      chk("rnd mem_en",   mem_en,   e_en);
      chk("rnd mem_we",   mem_we,   e_we);
      chk("rnd stall_if", stall_if, if_req & ~e_ifv);
      chk("rnd stall_d",  stall_d,  d_req & ~e_dv);
      if (e_en) chk("rnd mem_addr", mem_addr, m_addr);
      if (!if_req || if_valid) begin
        if ($urandom_range(0, 2) != 0) begin if_req = 1; if_addr = AW'($urandom); end
        else if_req = 0;
      end
      if (!d_req || d_valid) begin
        if ($urandom_range(0, 2) != 0) begin
          d_req = 1; d_we = 1'($urandom_range(0, 1));
          d_addr = AW'($urandom); d_wdata = $urandom;
        end else begin
          d_req = 0; d_we = 0;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
